// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch PC generator and its branch target buffer.
package pc_pkg;

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_e;

  // Next-PC source, listed highest priority first.
  typedef enum logic [1:0] {SRC_TRAP, SRC_EX, SRC_PRED, SRC_SEQ} src_e;

  localparam int unsigned INST_BYTES_DEF = 4;

  // True when the low log2(inst_bytes) bits of addr are zero.
  function automatic logic is_aligned(input logic [63:0] addr, input int unsigned inst_bytes);
    return (addr & 64'(inst_bytes - 1)) == 64'd0;
  endfunction

endpackage

// File: rtl/pc_btb.sv
// Direct-mapped BTB: combinational lookup, update lands at the clock edge.
// Lookup sees the old entry in the update cycle; valid bits clear on async reset.
module pc_btb #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-1:0] lookup_pc_i,
  output logic            hit_o,
  output logic [XLEN-1:0] target_o,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned TW = XLEN - IW - 2;

  logic [DEPTH-1:0] valid_q;
  logic [TW-1:0]    tag_q [DEPTH];
  logic [XLEN-1:0]  tgt_q [DEPTH];

  logic [IW-1:0] lk_idx, up_idx;
  logic [TW-1:0] lk_tag, up_tag;

  assign lk_idx = lookup_pc_i[IW+1:2];
  assign lk_tag = lookup_pc_i[XLEN-1:IW+2];
  assign up_idx = upd_pc_i[IW+1:2];
  assign up_tag = upd_pc_i[XLEN-1:IW+2];

  assign hit_o    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign target_o = tgt_q[lk_idx];

  // Instruction-granule offset bits never take part in indexing or tagging.
  logic unused_lo;
  assign unused_lo = ^{lookup_pc_i[1:0], upd_pc_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else if (upd_valid_i) begin
      if (upd_taken_i) begin
        valid_q[up_idx] <= 1'b1;
      end else if (tag_q[up_idx] == up_tag) begin
        valid_q[up_idx] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (upd_valid_i && upd_taken_i) begin
      tag_q[up_idx] <= up_tag;
      tgt_q[up_idx] <= upd_target_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: redirect-to-new-PC 1 cycle, valid again 1 cycle later (FLUSH bubble).
// PC/valid/prediction hold while fetch_ready_i=0 or stall_i=1; trap/ex redirects still apply.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned     XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_VEC  = '0,
  parameter int unsigned     BTB_DEPTH  = 8,
  parameter int unsigned     INST_BYTES = INST_BYTES_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            fetch_ready_i,
  output logic            fetch_valid_o,
  output logic [XLEN-1:0] fetch_pc_o,
  output logic            pred_taken_o,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vec_i,
  input  logic            ex_redirect_i,
  input  logic [XLEN-1:0] ex_target_i,
  input  logic            upd_valid_i,
  input  logic [XLEN-1:0] upd_pc_i,
  input  logic [XLEN-1:0] upd_target_i,
  input  logic            upd_taken_i,
  output logic            misalign_o
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;
  src_e            src;

  logic            btb_hit;
  logic [XLEN-1:0] btb_tgt;
  logic            ex_ok, live, advance;

  pc_btb #(.XLEN(XLEN), .DEPTH(BTB_DEPTH)) u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_pc_i (pc_q),
    .hit_o       (btb_hit),
    .target_o    (btb_tgt),
    .upd_valid_i (upd_valid_i),
    .upd_pc_i    (upd_pc_i),
    .upd_target_i(upd_target_i),
    .upd_taken_i (upd_taken_i)
  );

  assign ex_ok   = is_aligned(64'(ex_target_i), INST_BYTES);
  assign live    = (state_q != BOOT);
  assign advance = (state_q == RUN) && fetch_ready_i && !stall_i;

  always_comb begin
    src        = SRC_SEQ;
    pc_d       = pc_q;
    state_d    = state_q;
    misalign_d = live && ex_redirect_i && !ex_ok && !trap_i;

    if (live && trap_i) begin
      src = SRC_TRAP;
    end else if (live && ex_redirect_i && ex_ok) begin
      src = SRC_EX;
    end else if (btb_hit) begin
      src = SRC_PRED;
    end

    case (src)
      SRC_TRAP: pc_d = trap_vec_i;
      SRC_EX:   pc_d = ex_target_i;
      SRC_PRED: if (advance) pc_d = btb_tgt;
      default:  if (advance) pc_d = pc_q + XLEN'(INST_BYTES);
    endcase

    // Any accepted redirect (from RUN or FLUSH) buys one bubble; otherwise fall into RUN.
    case (state_q)
      BOOT:    state_d = RUN;
      default: state_d = (src == SRC_TRAP || src == SRC_EX) ? FLUSH : RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VEC;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign fetch_pc_o    = pc_q;
  assign fetch_valid_o = (state_q == RUN);
  assign pred_taken_o  = btb_hit && (state_q == RUN);
  assign misalign_o    = misalign_q;

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the instruction-fetch stage; replaces the fixed PC+4/branch-offset register.
- Presents fetch addresses to the fetch stage over a valid/ready handshake.
- Accepts trap and execute-stage redirects, and predicts taken branches with a small direct-mapped branch target buffer (BTB).
- Sits between the execute/trap logic and the instruction memory request port.

Parameters:
- XLEN, 32, PC and target width in bits.
- RESET_VEC, 32'h0000_0000, first fetch address after reset.
- BTB_DEPTH, 8, number of BTB entries; power of two, ≥2.
- INST_BYTES, 4, sequential increment; alignment is checked on log2(INST_BYTES) low bits.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  pipeline stall; hold the PC.
- fetch_ready_i  in  1  fetch stage accepts fetch_pc_o.
- fetch_valid_o  out  1  fetch_pc_o is a valid request.
- fetch_pc_o  out  XLEN  current fetch address.
- pred_taken_o  out  1  BTB hit on fetch_pc_o; next PC is the predicted target.
- trap_i  in  1  trap redirect request.
- trap_vec_i  in  XLEN  trap target.
- ex_redirect_i  in  1  execute-stage mispredict/jump redirect.
- ex_target_i  in  XLEN  redirect target.
- upd_valid_i  in  1  resolved-branch update to the BTB.
- upd_pc_i  in  XLEN  PC of the resolved branch.
- upd_target_i  in  XLEN  resolved target.
- upd_taken_i  in  1  branch was taken.
- misalign_o  out  1  one-cycle pulse: ex_target_i was misaligned.

Behaviour:
- Reset (asynchronous, any cycle, including mid-redirect):
  - pc = RESET_VEC, state = BOOT, all BTB valid bits cleared.
  - fetch_valid_o = 0, pred_taken_o = 0, misalign_o = 0.
- States:
  - BOOT: fetch_valid_o = 0 for exactly one cycle, then go to RUN.
  - RUN: fetch_valid_o = 1.
  - FLUSH: one bubble cycle after any accepted redirect; fetch_valid_o = 0; then go to RUN.
- Advance: in RUN, when fetch_ready_i = 1 and stall_i = 0, pc takes next_seq.
  - next_seq = BTB target if the lookup hits, otherwise pc + INST_BYTES.
  - Addition is modulo 2^XLEN; 0xFFFF_FFFC wraps to 0x0000_0000.
- Hold: when fetch_ready_i = 0 or stall_i = 1, pc, fetch_valid_o and pred_taken_o stay stable (handshake rule: valid must not drop without acceptance).
- Redirect priority, evaluated every cycle in all states except BOOT, regardless of stall_i and fetch_ready_i: trap_i > ex_redirect_i > BTB prediction > sequential.
  - Trap: pc = trap_vec_i, go to FLUSH.
  - ex_redirect_i with an aligned target: pc = ex_target_i, go to FLUSH.
  - ex_redirect_i with a misaligned target (low log2(INST_BYTES) bits ≠ 0): pc holds, misalign_o = 1 for one cycle, state unchanged.
  - Trap and misaligned redirect in the same cycle: the trap wins and misalign_o stays 0.
- Redirects during BOOT are ignored.
- Redirect in FLUSH: the new target overwrites pc and FLUSH is re-entered (one more bubble).
- BTB lookup (combinational on pc):
  - index = pc[log2(BTB_DEPTH)+1 : 2]; tag = pc[XLEN-1 : log2(BTB_DEPTH)+2].
  - Hit = valid && tag match. pred_taken_o = hit && state == RUN.
- BTB update (registered, on upd_valid_i):
  - upd_taken_i = 1: write {valid = 1, tag, upd_target_i} at the index of upd_pc_i.
  - upd_taken_i = 0: clear valid only if the tag matches.
  - A lookup and an update to the same index in the same cycle: the lookup sees the old entry; the new contents are visible next cycle.
  - Updates are processed during stall and FLUSH.
- Latency: redirect to new fetch_pc_o visible = 1 cycle; fetch_valid_o is asserted 2 cycles after the redirect.

Decomposition:
- Shared package pc_pkg:
  - state enum {BOOT, RUN, FLUSH}.
  - Redirect-source priority encoding {SRC_TRAP, SRC_EX, SRC_PRED, SRC_SEQ}.
  - Default INST_BYTES constant.
  - Helper function for the alignment check.
- One sub-module, pc_btb: tag/target/valid arrays, combinational lookup, registered update, asynchronous clear of valid bits.
- pc_gen contains only the FSM, next-PC mux and PC register.

Test Plan:
- Reset release, fetch_ready_i = 1 → fetch_valid_o = 0 for one cycle, then fetch_pc_o = 0x0, 0x4, 0x8, 0xC on consecutive cycles; pred_taken_o = 0.
- fetch_ready_i = 0 for 3 cycles at pc 0x8 → fetch_pc_o holds 0x8 and fetch_valid_o holds 1; on release, next pc is 0xC.
- Redirect priority:
  - ex_redirect_i with target 0x100 while stall_i = 1 → next cycle fetch_pc_o = 0x100, fetch_valid_o = 0, then 1.
  - trap_i (vec 0x80) together with ex_redirect_i (target 0x100) → pc = 0x80.
- BTB training:
  - upd_valid_i / upd_taken_i with upd_pc_i = 0x10, target 0x40; run from 0x0 → at 0x10 pred_taken_o = 1 and the next pc = 0x40.
  - Then not-taken update for 0x10 → the next pass goes 0x10 → 0x14.
- ex_target_i = 0x102 → misalign_o pulses 1 for one cycle, pc unchanged; same with trap_i = 1 → pc = trap_vec_i, misalign_o = 0.
- Wrap and reset:
  - XLEN = 32, redirect to 0xFFFF_FFFC → next pc = 0x0000_0000.
  - Assert rst_n low mid-FLUSH → outputs 0 immediately, BTB empty (no pred_taken_o at 0x10 afterwards).
